// File: rtl/alarm_clock_core_if.sv
// ---------------------------------------------------------------------------
// alarm_clock_core_if
//   Groups the buttons, mode switches and displays of the alarm clock core.
//   master : the panel side (drives buttons/modes, reads time and alarm status)
//   slave  : the core side (reads buttons/modes, drives time and alarm status)
//   Signals:
//     Timeset, Alarmset        mode switches
//     Minadv, Hrsadv, Dayadv   advance buttons
//     Alarmon, Snooze          alarm arm and snooze button
//     AlarmDays[ND-1:0]        per-day alarm enable
//     TSec, TMin, THrs, TDay   current time
//     DispMin, DispHrs         display source (alarm or time)
//     Buzz, Snoozing           alarm status
// ---------------------------------------------------------------------------
interface alarm_clock_core_if #(
    parameter int ND = 7
);
    localparam int DW = (ND > 1) ? $clog2(ND) : 1;

    logic          Timeset;
    logic          Alarmset;
    logic          Minadv;
    logic          Hrsadv;
    logic          Dayadv;
    logic          Alarmon;
    logic          Snooze;
    logic [ND-1:0] AlarmDays;

    logic [6:0]    TSec;
    logic [6:0]    TMin;
    logic [6:0]    THrs;
    logic [DW-1:0] TDay;
    logic [6:0]    DispMin;
    logic [6:0]    DispHrs;
    logic          Buzz;
    logic          Snoozing;

    modport master (
        output Timeset, Alarmset, Minadv, Hrsadv, Dayadv, Alarmon, Snooze, AlarmDays,
        input  TSec, TMin, THrs, TDay, DispMin, DispHrs, Buzz, Snoozing
    );

    modport slave (
        input  Timeset, Alarmset, Minadv, Hrsadv, Dayadv, Alarmon, Snooze, AlarmDays,
        output TSec, TMin, THrs, TDay, DispMin, DispHrs, Buzz, Snoozing
    );
endinterface

// File: rtl/alarm_clock_core.sv
// ---------------------------------------------------------------------------
// alarm_clock_core
//   Seconds/minutes/hours/day clock with time-set and alarm-set modes and a
//   per-day alarm that rings, can be snoozed a limited number of times and
//   stops by itself after RING_S pulses.
//   Ports:
//     Pulse  : one clock per second, all state updates on its rising edge
//     Reset  : asynchronous, active-low reset
//     bus    : alarm_clock_core_if slave (buttons, modes, time, alarm status)
// ---------------------------------------------------------------------------
module alarm_clock_core #(
    parameter int NS         = 60,
    parameter int NM         = 60,
    parameter int NH         = 24,
    parameter int ND         = 7,
    parameter int SNOOZE_MIN = 9,
    parameter int RING_S     = 60,
    parameter int MAX_SNOOZE = 3
) (
    input  logic              Pulse,
    input  logic              Reset,
    alarm_clock_core_if.slave bus
);
    localparam int DW        = (ND > 1) ? $clog2(ND) : 1;
    localparam int RW        = (RING_S > 1) ? $clog2(RING_S) : 1;
    localparam int SNZ_LOAD  = SNOOZE_MIN * NS - 1;
    localparam int TW        = (SNZ_LOAD > 0) ? $clog2(SNZ_LOAD + 1) : 1;
    localparam int CW        = $clog2(MAX_SNOOZE + 1);

    localparam logic [6:0]    SEC_MAX  = 7'(NS - 1);
    localparam logic [6:0]    MIN_MAX  = 7'(NM - 1);
    localparam logic [6:0]    HRS_MAX  = 7'(NH - 1);
    localparam logic [DW-1:0] DAY_MAX  = DW'(ND - 1);
    localparam logic [RW-1:0] RING_END = RW'(RING_S - 1);
    localparam logic [TW-1:0] SNZ_INIT = TW'(SNZ_LOAD);
    localparam logic [CW-1:0] SNZ_MAX  = CW'(MAX_SNOOZE);

    typedef enum logic [1:0] {
        IDLE,
        RINGING,
        SNOOZE
    } alarm_state_e;

    function automatic logic [6:0] inc_wrap(input logic [6:0] v, input logic [6:0] max);
        return (v == max) ? 7'd0 : v + 7'd1;
    endfunction

    // Time-set wins over alarm-set when both switches are on.
    logic time_set;
    logic alarm_set;
    assign time_set  = bus.Timeset;
    assign alarm_set = bus.Alarmset & ~bus.Timeset;

    logic [6:0]    sec_q,  sec_d;
    logic [6:0]    min_q,  min_d;
    logic [6:0]    hrs_q,  hrs_d;
    logic [DW-1:0] day_q,  day_d;
    logic [6:0]    amin_q, amin_d;
    logic [6:0]    ahrs_q, ahrs_d;

    alarm_state_e  state_q, state_d;
    logic [RW-1:0] ring_cnt_q, ring_cnt_d;
    logic [TW-1:0] snz_tmr_q,  snz_tmr_d;
    logic [CW-1:0] snz_cnt_q,  snz_cnt_d;

    // ---------------- time and alarm registers ----------------
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        sec_d  = sec_q;
        min_d  = min_q;
        hrs_d  = hrs_q;
        day_d  = day_q;
        amin_d = amin_q;
        ahrs_d = ahrs_q;

        if (time_set) begin
            // Each field advances on its own button, wrapping without carry.
            sec_d = '0;
            if (bus.Minadv) min_d = inc_wrap(min_q, MIN_MAX);
            if (bus.Hrsadv) hrs_d = inc_wrap(hrs_q, HRS_MAX);
            if (bus.Dayadv) day_d = (day_q == DAY_MAX) ? '0 : day_q + DW'(1);
        end else begin
            sec_d = inc_wrap(sec_q, SEC_MAX);
            if (sec_q == SEC_MAX) begin
                min_d = inc_wrap(min_q, MIN_MAX);
                if (min_q == MIN_MAX) begin
                    hrs_d = inc_wrap(hrs_q, HRS_MAX);
                    if (hrs_q == HRS_MAX)
                        day_d = (day_q == DAY_MAX) ? '0 : day_q + DW'(1);
                end
            end
        end

        if (alarm_set) begin
            if (bus.Minadv) amin_d = inc_wrap(amin_q, MIN_MAX);
            if (bus.Hrsadv) ahrs_d = inc_wrap(ahrs_q, HRS_MAX);
        end
    end

    // ---------------- alarm FSM ----------------
    logic alarm_match;
    assign alarm_match = bus.Alarmon && !time_set && (sec_q == '0) &&
                         (min_q == amin_q) && (hrs_q == ahrs_q) && bus.AlarmDays[day_q];

    always_comb begin
        state_d    = state_q;
        ring_cnt_d = ring_cnt_q;
        snz_tmr_d  = snz_tmr_q;
        snz_cnt_d  = snz_cnt_q;

        unique case (state_q)
            IDLE: begin
                if (alarm_match) begin
                    state_d    = RINGING;
                    ring_cnt_d = '0;
                    snz_cnt_d  = '0;
                end
            end
            RINGING: begin
                ring_cnt_d = ring_cnt_q + RW'(1);
                if (time_set || !bus.Alarmon) begin
                    state_d = IDLE;
                end else if (bus.Snooze && (snz_cnt_q < SNZ_MAX)) begin
                    state_d   = SNOOZE;
                    snz_tmr_d = SNZ_INIT;
                    snz_cnt_d = snz_cnt_q + CW'(1);
                end else if (ring_cnt_q == RING_END) begin
                    state_d = IDLE;
                end
            end
            SNOOZE: begin
                snz_tmr_d = snz_tmr_q - TW'(1);
                if (time_set || !bus.Alarmon) begin
                    state_d = IDLE;
                end else if (snz_tmr_q == '0) begin
                    // Re-ring exactly SNOOZE_MIN*NS pulses after the snooze edge.
                    state_d    = RINGING;
                    ring_cnt_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Pulse or negedge Reset) begin
        if (!Reset) begin
            sec_q      <= '0;
            min_q      <= '0;
            hrs_q      <= '0;
            day_q      <= '0;
            amin_q     <= '0;
            ahrs_q     <= '0;
            state_q    <= IDLE;
            ring_cnt_q <= '0;
            snz_tmr_q  <= '0;
            snz_cnt_q  <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            sec_q      <= sec_d;
            min_q      <= min_d;
            hrs_q      <= hrs_d;
            day_q      <= day_d;
            amin_q     <= amin_d;
            ahrs_q     <= ahrs_d;
            state_q    <= state_d;
            ring_cnt_q <= ring_cnt_d;
            snz_tmr_q  <= snz_tmr_d;
            snz_cnt_q  <= snz_cnt_d;
        end
    end

    // ---------------- outputs ----------------
    // Buzz/Snoozing decode straight from the state flop, so reset clears them
    // at once and release cannot glitch them.
    assign bus.TSec     = sec_q;
    assign bus.TMin     = min_q;
    assign bus.THrs     = hrs_q;
    assign bus.TDay     = day_q;
    assign bus.DispMin  = alarm_set ? amin_q : min_q;
    assign bus.DispHrs  = alarm_set ? ahrs_q : hrs_q;
    assign bus.Buzz     = (state_q == RINGING);
    assign bus.Snoozing = (state_q == SNOOZE);

endmodule
